// File: rtl/cb_inreq_if.sv
// Handshake bundle for one crossbar input channel: upstream flit push,
// crossbar request/grant, downstream credit return and error reporting.
interface cb_inreq_if #(
  parameter int DATAW = 64,
  parameter int VCHW  = 1
);
  logic             in_valid;
  logic [DATAW-1:0] in_data;
  logic [VCHW-1:0]  in_vch;
  logic [4:0]       in_dst;
  logic             in_ready;

  logic             req;
  logic [2:0]       port;
  logic [4:0]       multab;
  logic [4:0]       grt;

  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCHW-1:0]  ivch;

  logic [4:0]       cred_ret;
  logic             err;

  modport slave (
    input  in_valid, in_data, in_vch, in_dst, grt, cred_ret,
    output in_ready, req, port, multab, idata, ivalid, ivch, err
  );

  modport master (
    output in_valid, in_data, in_vch, in_dst, grt, cred_ret,
    input  in_ready, req, port, multab, idata, ivalid, ivch, err
  );
endinterface

// File: rtl/cb_inreq.sv
// Crossbar input-port requester: FIFO-buffered flits, multicast delivery over
// several grant cycles, and per-output credit tracking.
module cb_inreq #(
  parameter int DATAW   = 64,
  parameter int VCHW    = 1,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst_,
  cb_inreq_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX     = CW'(CREDITS);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATAW-1:0] data_mem [DEPTH];
  logic [VCHW-1:0]  vch_mem  [DEPTH];
  logic [4:0]       dst_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    served;
  logic [CW-1:0] cnt [5];
  logic          err_q;

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [4:0] grt;
  logic [4:0] cred_ret;
  logic [4:0] rem;
  logic [4:0] cnz;
  logic [4:0] elig;
  logic       req;
  logic [4:0] xfer;
  logic [2:0] port;
  logic       grant_err;
  logic       cred_err;
  logic       drop_err;

  assign grt      = bus.grt;
  assign cred_ret = bus.cred_ret;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;

  // served tracks destinations already delivered for the current head only
  assign rem = empty ? 5'b0 : (dst_mem[rd_ptr] & ~served);

  always_comb begin
    cnz = '0;
    for (int i = 0; i < 5; i++) begin
      cnz[i] = (cnt[i] != '0);
    end
  end

  assign elig = rem & cnz;
  assign req  = !empty && (elig != 5'b0);
  assign xfer = grt & elig & {5{req}};
  assign pop  = !empty && ((rem & ~xfer) == 5'b0);

  always_comb begin
    port = '0;
    for (int i = 4; i >= 0; i--) begin
      if (elig[i]) begin
        port = 3'(i);
      end
    end
  end

  assign grant_err = req ? ((grt & ~elig) != 5'b0) : (grt != 5'b0);
  assign drop_err  = bus.in_valid && full;

  always_comb begin
    cred_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (cred_ret[i] && !xfer[i] && (cnt[i] == CMAX)) begin
        cred_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.in_data;
      vch_mem[wr_ptr]  <= bus.in_vch;
      dst_mem[wr_ptr]  <= bus.in_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      served <= '0;
    end else if (pop) begin
      served <= '0;
    end else begin
      served <= served | xfer;
    end
  end

  // A grant consumes a credit and a return restores one; both together cancel
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= CMAX;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (xfer[i] && !cred_ret[i]) begin
          cnt[i] <= cnt[i] - CW'(1);
        end else if (!xfer[i] && cred_ret[i] && (cnt[i] != CMAX)) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q <= 1'b0;
    end else if (grant_err || cred_err || drop_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.in_ready = !full;
  assign bus.req      = req;
  assign bus.port     = port;
  assign bus.multab   = req ? elig : 5'b0;
  assign bus.idata    = data_mem[rd_ptr];
  assign bus.ivch     = vch_mem[rd_ptr];
  assign bus.ivalid   = (xfer != 5'b0);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_cb_inreq.sv
// Self-checking bench for cb_inreq: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cb_inreq;

  localparam int DATAW   = 64;
  localparam int VCHW    = 1;
  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  cb_inreq_if #(.DATAW(DATAW), .VCHW(VCHW)) bus ();

  cb_inreq #(
    .DATAW(DATAW), .VCHW(VCHW), .DEPTH(DEPTH), .CREDITS(CREDITS)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATAW-1:0] data;
    logic [VCHW-1:0]  vch;
    logic [4:0]       dst;
  } flit_t;

  flit_t      q[$];
  logic [4:0] m_served;
  int         m_cred[5];
  bit         m_err;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Destinations of the head flit that are still owed and have credit
  function automatic logic [4:0] m_elig();
    logic [4:0] e;
    e = '0;
    if (q.size() != 0) begin
      for (int i = 0; i < 5; i++) begin
        if (q[0].dst[i] && !m_served[i] && m_cred[i] > 0) e[i] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_served = '0;
    m_err    = 1'b0;
    for (int i = 0; i < 5; i++) m_cred[i] = CREDITS;
  endtask

  task automatic model_step();
    logic [4:0] e;
    logic [4:0] x;
    bit         r;
    bit         can_push;
    flit_t      f;
    e = m_elig();
    r = (e != 0);
    x = r ? (bus.grt & e) : 5'b0;
    if (r ? ((bus.grt & ~e) != 0) : (bus.grt != 0)) m_err = 1'b1;
    can_push = (q.size() < DEPTH);
    if (bus.in_valid && !can_push) m_err = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_cred[i] = m_cred[i] - int'(x[i]) + int'(bus.cred_ret[i]);
      if (m_cred[i] > CREDITS) begin
        m_err     = 1'b1;
        m_cred[i] = CREDITS;
      end
    end
    if (q.size() != 0 && ((q[0].dst & ~m_served & ~x) == 0)) begin
      void'(q.pop_front());
      m_served = '0;
    end else begin
      m_served = m_served | x;
    end
    if (bus.in_valid && can_push) begin
      f.data = bus.in_data;
      f.vch  = bus.in_vch;
      f.dst  = bus.in_dst;
      q.push_back(f);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_);
      if (!rst_) model_reset();
      else model_step();
    end
  end

  // Every mid-cycle, outputs must match what the model derives from its state
  always @(negedge clk) begin : compare
    logic [4:0] e;
    logic       r;
    int         p;
    if (rst_) begin
      e = m_elig();
      r = (e != 0);
      p = 0;
      for (int i = 0; i < 5; i++) begin
        if (e[i]) begin
          p = i;
          break;
        end
      end
      checkOutput("m_in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
      checkOutput("m_req",      64'(bus.req),      64'(r));
      checkOutput("m_multab",   64'(bus.multab),   64'(r ? e : 5'b0));
      checkOutput("m_port",     64'(bus.port),     64'(p));
      checkOutput("m_ivalid",   64'(bus.ivalid),   64'(r && ((bus.grt & e) != 0)));
      checkOutput("m_err",      64'(bus.err),      64'(m_err));
      if (q.size() != 0) begin
        checkOutput("m_idata", 64'(bus.idata), 64'(q[0].data));
        checkOutput("m_ivch",  64'(bus.ivch),  64'(q[0].vch));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [63:0] d,
                               input logic [VCHW-1:0] vc, input logic [4:0] dst,
                               input logic [4:0] g, input logic [4:0] r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_vch   = vc;
    bus.in_dst   = dst;
    bus.grt      = g;
    bus.cred_ret = r;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 64'h0, '0, 5'b0, 5'b0, 5'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    idle();
    rst_ = 1'b0;
    #2;
    @(negedge clk);
    rst_ = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    idle();
    #12;
    checkOutput("rst_req",      64'(bus.req),      'h0);
    checkOutput("rst_ivalid",   64'(bus.ivalid),   'h0);
    checkOutput("rst_port",     64'(bus.port),     'h0);
    checkOutput("rst_multab",   64'(bus.multab),   'h0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 'h1);
    checkOutput("rst_err",      64'(bus.err),      'h0);
    @(negedge clk);
    rst_ = 1'b1;
    step();

    // Unicast to port 2
    applyStimulus(1'b1, 64'hA5, 1'b1, 5'b00100, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("uni_req",    64'(bus.req),    'h1);
    checkOutput("uni_port",   64'(bus.port),   'h2);
    checkOutput("uni_multab", 64'(bus.multab), 'b00100);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00100, 5'b0); #1;
    checkOutput("uni_ivalid", 64'(bus.ivalid), 'h1);
    checkOutput("uni_idata",  64'(bus.idata),  'hA5);
    checkOutput("uni_ivch",   64'(bus.ivch),   'h1);
    step(); idle(); #1;
    checkOutput("uni_req_after", 64'(bus.req), 'h0);
    checkOutput("uni_model_empty", 64'(q.size()), 'h0);
    checkOutput("uni_model_cnt2", 64'(m_cred[2]), 'h3);

    // Multicast with partial grant
    applyReset();
    applyStimulus(1'b1, 64'h1234, 1'b0, 5'b10011, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("mc_multab0", 64'(bus.multab), 'b10011);
    checkOutput("mc_port0",   64'(bus.port),   'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0); #1;
    checkOutput("mc_ivalid0", 64'(bus.ivalid), 'h1);
    step(); idle(); #1;
    checkOutput("mc_req1",    64'(bus.req),    'h1);
    checkOutput("mc_multab1", 64'(bus.multab), 'b10010);
    checkOutput("mc_port1",   64'(bus.port),   'h1);
    checkOutput("mc_idata1",  64'(bus.idata),  'h1234);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b10010, 5'b0); #1;
    checkOutput("mc_ivalid1", 64'(bus.ivalid), 'h1);
    step(); idle(); #1;
    checkOutput("mc_req_after", 64'(bus.req), 'h0);
    checkOutput("mc_model_cnt0", 64'(m_cred[0]), 'h3);
    checkOutput("mc_model_cnt1", 64'(m_cred[1]), 'h3);
    checkOutput("mc_model_cnt4", 64'(m_cred[4]), 'h3);

    // Zero-destination flit is discarded without requesting
    applyReset();
    applyStimulus(1'b1, 64'h1, 1'b0, 5'b00000, 5'b0, 5'b0);
    step();
    applyStimulus(1'b1, 64'h2, 1'b0, 5'b00010, 5'b0, 5'b0); #1;
    checkOutput("dst0_req",    64'(bus.req),    'h0);
    checkOutput("dst0_ivalid", 64'(bus.ivalid), 'h0);
    step(); idle(); #1;
    checkOutput("dst0_next_req",   64'(bus.req),   'h1);
    checkOutput("dst0_next_port",  64'(bus.port),  'h1);
    checkOutput("dst0_next_idata", 64'(bus.idata), 'h2);

    // Credit stall on port 3
    applyReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'(k), 1'b0, 5'b01000, 5'b0, 5'b0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b01000, 5'b0); #1;
      checkOutput("cs_drain_ivalid", 64'(bus.ivalid), 'h1);
      checkOutput("cs_drain_idata",  64'(bus.idata),  64'(k));
      step();
    end
    applyStimulus(1'b1, 64'h55, 1'b0, 5'b01000, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("cs_stall_req", 64'(bus.req), 'h0);
    checkOutput("cs_model_cnt3_zero", 64'(m_cred[3]), 'h0);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b0, 5'b01000);
    step(); idle(); #1;
    checkOutput("cs_ret_req",    64'(bus.req),    'h1);
    checkOutput("cs_ret_port",   64'(bus.port),   'h3);
    checkOutput("cs_ret_multab", 64'(bus.multab), 'b01000);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b01000, 5'b01000); #1;
    checkOutput("cs_both_ivalid", 64'(bus.ivalid), 'h1);
    checkOutput("cs_both_idata",  64'(bus.idata),  'h55);
    step(); idle(); #1;
    checkOutput("cs_model_cnt3_one", 64'(m_cred[3]), 'h1);
    applyStimulus(1'b1, 64'h66, 1'b0, 5'b01000, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("cs_one_left_req", 64'(bus.req), 'h1);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b01000, 5'b0);
    step();
    applyStimulus(1'b1, 64'h77, 1'b0, 5'b01000, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("cs_none_left_req", 64'(bus.req), 'h0);

    // Full FIFO, dropped push, push+pop at occupancy 3
    applyReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'(8'h10 + k), 1'b0, 5'b00001, 5'b0, 5'b0);
      step();
    end
    idle(); #1;
    checkOutput("full_in_ready", 64'(bus.in_ready), 'h0);
    applyStimulus(1'b1, 64'hEE, 1'b0, 5'b00001, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("full_drop_err", 64'(bus.err), 'h1);
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0); #1;
    checkOutput("full_pop_idata", 64'(bus.idata), 'h10);
    step(); idle(); #1;
    checkOutput("full_ready_again", 64'(bus.in_ready), 'h1);
    applyStimulus(1'b1, 64'h20, 1'b0, 5'b00001, 5'b00001, 5'b0); #1;
    checkOutput("pp_idata", 64'(bus.idata), 'h11);
    step(); idle(); #1;
    checkOutput("pp_model_occ", 64'(q.size()), 'h3);
    checkOutput("pp_in_ready",  64'(bus.in_ready), 'h1);
    for (int k = 2; k < 4; k++) begin
      applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0); #1;
      checkOutput("pp_drain_idata", 64'(bus.idata), 64'(8'h10 + k));
      step();
    end
    idle(); #1;
    checkOutput("pp_tail_idata", 64'(bus.idata), 'h20);
    checkOutput("pp_tail_stall", 64'(bus.req),   'h0);

    // Protocol errors
    applyReset();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0); #1;
    checkOutput("err_not_yet", 64'(bus.err), 'h0);
    step(); idle(); #1;
    checkOutput("err_grant_no_req", 64'(bus.err), 'h1);
    applyReset();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b0, 5'b00001);
    step(); idle(); #1;
    checkOutput("err_cred_over", 64'(bus.err), 'h1);
    checkOutput("err_model_cnt0", 64'(m_cred[0]), 'h4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 64'(k), 1'b0, 5'b00001, 5'b0, 5'b0);
      step();
      applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0); #1;
      checkOutput("sat_ivalid", 64'(bus.ivalid), 'h1);
      step();
    end
    applyStimulus(1'b1, 64'h9, 1'b0, 5'b00001, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("sat_fifth_req", 64'(bus.req), 'h0);
    applyReset();
    applyStimulus(1'b1, 64'h3, 1'b0, 5'b00001, 5'b0, 5'b0);
    step();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00011, 5'b0); #1;
    checkOutput("err_out_ivalid", 64'(bus.ivalid), 'h1);
    step(); idle(); #1;
    checkOutput("err_outside_elig", 64'(bus.err), 'h1);
    checkOutput("err_outside_req",  64'(bus.req), 'h0);

    // Asynchronous reset in the middle of a multicast
    applyReset();
    applyStimulus(1'b1, 64'hBEEF, 1'b1, 5'b10011, 5'b0, 5'b0);
    step();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00100, 5'b0);
    step();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b00001, 5'b0);
    step();
    applyStimulus(1'b0, 64'h0, 1'b0, 5'b0, 5'b10010, 5'b0); #1;
    checkOutput("ar_pre_ivalid", 64'(bus.ivalid), 'h1);
    checkOutput("ar_pre_multab", 64'(bus.multab), 'b10010);
    checkOutput("ar_pre_err",    64'(bus.err),    'h1);
    rst_ = 1'b0; #1;
    checkOutput("ar_req",      64'(bus.req),      'h0);
    checkOutput("ar_ivalid",   64'(bus.ivalid),   'h0);
    checkOutput("ar_in_ready", 64'(bus.in_ready), 'h1);
    checkOutput("ar_err",      64'(bus.err),      'h0);
    idle();
    @(negedge clk);
    rst_ = 1'b1;
    step(); #1;
    checkOutput("ar_post_req", 64'(bus.req), 'h0);
    checkOutput("ar_post_model_occ", 64'(q.size()), 'h0);
    for (int i = 0; i < 5; i++) checkOutput("ar_post_model_cnt", 64'(m_cred[i]), 'h4);
    applyStimulus(1'b1, 64'h42, 1'b0, 5'b11111, 5'b0, 5'b0);
    step(); idle(); #1;
    checkOutput("ar_post_multab", 64'(bus.multab), 'b11111);
    checkOutput("ar_post_port",   64'(bus.port),   'h0);
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cb_inreq.md
Name: cb_inreq

Overview:
- Input-port side of the 5-port crossbar handshake: one instance per router input channel.
- Buffers incoming flits in a FIFO, presents the head flit to the crossbar as req/port/multab plus idata/ivalid/ivch, and consumes the per-output grant vector.
- A multicast flit is delivered to every output in its destination mask, possibly over several cycles, and popped only when all destinations are served.
- Tracks downstream per-output credits so that it never requests an output without buffer space.

Parameters:
- DATAW, 64, flit data width in bits.
- VCHW, 1, virtual-channel id width in bits.
- DEPTH, 4, input FIFO depth in flits (power of 2, ≥2).
- CREDITS, 4, initial and maximum credit count per output port.

Ports:
- clk  input  1  clock.
- rst_  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  upstream flit valid.
- in_data  input  DATAW  upstream flit payload.
- in_vch  input  VCHW  upstream flit VC id.
- in_dst  input  5  destination mask, one bit per output port 0..4.
- in_ready  output  1  FIFO can accept a flit this cycle.
- req  output  1  request to crossbar.
- port  output  3  lowest-index eligible output port (0..4).
- multab  output  5  eligible destination mask presented to the crossbar.
- grt  input  5  grant vector from crossbar, bit i = output i granted to this input.
- idata  output  DATAW  head flit payload.
- ivalid  output  1  flit transferred this cycle.
- ivch  output  VCHW  head flit VC id.
- cred_ret  input  5  one-cycle credit-return pulse per output port.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_=0, async): FIFO empty; rem mask=0; all credit counters=CREDITS; err=0. Consequently req=0, ivalid=0, port=0, multab=0, in_ready=1. idata and ivch are don't-care but driven from storage.
- Push: occurs when in_valid & in_ready at the clock edge. in_ready = !full and does not depend on a same-cycle pop. Push and pop in the same cycle are legal when not full; occupancy is unchanged. Pointers wrap modulo DEPTH.
- A pushed flit reaches the head at the earliest on the next cycle. There is no bypass.
- rem: remaining-destination mask of the head flit. It is loaded from the stored dst when a new flit becomes head. Implement this as a per-entry dst stored in the FIFO plus a served mask cleared on pop: rem = dst & ~served.
- elig = rem & credit_nonzero, where credit_nonzero[i] = (cnt[i] != 0).
- req = !empty & (elig != 0).
- multab = elig when req is 1, else 0.
- port = index of the lowest set bit of elig, else 0.
- idata and ivch come combinationally from the FIFO head.
- Grants are accepted in the same cycle: xfer = grt & elig & {5{req}}.
- ivalid = |xfer, combinational in the same cycle.
- At the clock edge:
  - served |= xfer.
  - cnt[i] -= xfer[i], then cnt[i] += cred_ret[i]. When both occur on the same port, the count is unchanged.
- Pop: occurs when (rem & ~xfer) == 0 at the edge, i.e. the last destination is served. served then clears for the next head.
- A head flit with dst=0 is popped in one cycle with req=0 and ivalid=0.
- Multicast: a flit receiving a partial grant is not popped. The remaining bits re-request on following cycles. Latency from a full grant to the next head's req is 1 cycle.
- A port with zero credit is masked from elig. The flit waits with req=0 if no other destinations remain.
- Error conditions, each of which sets err=1 until reset:
  - a grt bit outside elig while req=1;
  - grt != 0 while req=0;
  - a credit return that would take cnt above CREDITS (the count saturates at CREDITS);
  - in_valid with in_ready=0. The flit is dropped and the FIFO is unchanged.
- Counter widths: ceil(log2(CREDITS+1)) bits.
- Reset mid-operation: state clears immediately. Flits in flight are discarded; no ivalid follows.

Test Plan:
- Unicast: push data=0xA5, vch=1, dst=00100. Next cycle req=1, port=2, multab=00100. Drive grt=00100 → ivalid=1, idata=0xA5, ivch=1. FIFO is empty the next cycle and cnt[2]=3.
- Multicast partial: dst=10011, grt=00001 in cycle 1 → ivalid=1, no pop. Cycle 2: multab=10010, port=1. grt=10010 → pop. cnt0=cnt1=cnt4=3.
- Credit stall: drain port 3 with 4 granted flits (cnt3=0). A fifth flit dst=01000 gives req=0. Pulse cred_ret=01000 → req=1 the next cycle. Same-cycle grant plus return on port 3 leaves cnt3 unchanged.
- Full/backpressure: push 4 flits with no grants → in_ready=0. Push attempt while full → err=1, 5th flit absent. Grant the head → in_ready=1 the next cycle. Push and pop in the same cycle keeps occupancy at 3.
- Errors: grt=00001 while req=0 → err=1. cred_ret on a port at CREDITS → err=1, cnt stays 4.
- Async reset: assert rst_=0 mid-multicast (served=00001), without waiting for a clock edge → req=0, ivalid=0, in_ready=1, err=0 immediately. After release the FIFO is empty and all counters=4.
